// File: rtl/multdiv_sequencer_pkg.sv
// Shared processor constants: sequencer FSM encoding, rstatus codes
// and architectural register numbers.
package multdiv_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_RUN   = 2'd2,
        ST_WB    = 2'd3
    } md_state_e;

    localparam int unsigned EXC_ADD      = 1;
    localparam int unsigned EXC_ADDI     = 2;
    localparam int unsigned EXC_SUB      = 3;
    localparam int unsigned EXC_MULT_DEF = 4;
    localparam int unsigned EXC_DIV_DEF  = 5;

    localparam logic [4:0] R0      = 5'd0;
    localparam logic [4:0] RSTATUS = 5'd30;

    typedef struct packed {
        logic       is_div;
        logic [4:0] rd;
    } md_op_t;

    typedef struct packed {
        logic        exc;
        logic [31:0] data;
    } md_res_t;

endpackage

// File: rtl/multdiv_sequencer_if.sv
// Bundle between the X/W stages, the mult/div unit and the sequencer.
interface multdiv_sequencer_if;

    logic        issue_valid;
    logic        issue_is_div;
    logic [4:0]  issue_rd;
    logic        md_ctrl_mult;
    logic        md_ctrl_div;
    logic        md_ready;
    logic        md_exception;
    logic [31:0] md_result;
    logic        w_we;
    logic        stall;
    logic        done;
    logic        wb_valid;
    logic [4:0]  wb_reg;
    logic [31:0] wb_data;
    logic        busy;
    logic [4:0]  busy_rd;
    logic        timeout_err;

    modport master (
        input  issue_valid, issue_is_div, issue_rd,
        input  md_ready, md_exception, md_result, w_we,
        output md_ctrl_mult, md_ctrl_div, stall, done,
        output wb_valid, wb_reg, wb_data,
        output busy, busy_rd, timeout_err
    );

    modport slave (
        output issue_valid, issue_is_div, issue_rd,
        output md_ready, md_exception, md_result, w_we,
        input  md_ctrl_mult, md_ctrl_div, stall, done,
        input  wb_valid, wb_reg, wb_data,
        input  busy, busy_rd, timeout_err
    );

endinterface

// File: rtl/multdiv_sequencer_md_timeout_counter.sv
// Saturating RUN-cycle counter with a terminal flag at TIMEOUT-1.
module md_timeout_counter #(
    parameter int TIMEOUT = 64,
    parameter int CW      = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1
) (
    input  logic clock,
    input  logic reset,
    input  logic i_clr,
    input  logic i_en,
    output logic o_term
);

    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0] r_cnt;

    // Stops at LAST so a non-power-of-two TIMEOUT never wraps.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en && !o_term) begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    assign o_term = (r_cnt == LAST);

endmodule

// File: rtl/multdiv_sequencer.sv
// Sequences the shared mult/div unit: start pulse, pipeline stall,
// result capture and regfile write-port arbitration against W.
module multdiv_sequencer
    import multdiv_sequencer_pkg::*;
#(
    parameter int          TIMEOUT  = 64,
    parameter int unsigned EXC_MULT = EXC_MULT_DEF,
    parameter int unsigned EXC_DIV  = EXC_DIV_DEF
) (
    input  logic                clock,
    input  logic                reset,
    multdiv_sequencer_if.master bus
);

    md_state_e r_state;
    md_state_e w_next;
    md_op_t    r_op;
    md_res_t   r_res;
    logic      r_timeout_err;
    logic      w_term;
    logic      w_accept;
    logic      w_run;

    assign w_accept = (r_state == ST_IDLE) && bus.issue_valid;
    assign w_run    = (r_state == ST_RUN);

    md_timeout_counter #(
        .TIMEOUT (TIMEOUT)
    ) u_cnt (
        .clock  (clock),
        .reset  (reset),
        .i_clr  (w_accept),
        .i_en   (w_run),
        .o_term (w_term)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            ST_IDLE:  if (bus.issue_valid) w_next = ST_START;
            ST_START: w_next = ST_RUN;
            ST_RUN:   if (bus.md_ready || w_term) w_next = ST_WB;
            ST_WB:    if (!bus.w_we) w_next = ST_IDLE;
            default:  w_next = ST_IDLE;
        endcase
    end

    // md_ready wins over the terminal count in the last RUN cycle.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_op          <= '0;
            r_res         <= '0;
            r_timeout_err <= 1'b0;
        end else if (w_accept) begin
            r_op  <= '{is_div: bus.issue_is_div, rd: bus.issue_rd};
            r_res <= '0;
        end else if (w_run) begin
            if (bus.md_ready) begin
                r_res <= '{exc: bus.md_exception, data: bus.md_result};
            end else if (w_term) begin
                r_res.exc     <= 1'b1;
                r_timeout_err <= 1'b1;
            end
        end
    end

    always_comb begin
        bus.md_ctrl_mult = 1'b0;
        bus.md_ctrl_div  = 1'b0;
        bus.stall        = 1'b0;
        bus.done         = 1'b0;
        bus.wb_reg       = R0;
        bus.wb_data      = '0;
        unique case (r_state)
            ST_IDLE: bus.stall = bus.issue_valid;
            ST_START: begin
                bus.stall        = 1'b1;
                bus.md_ctrl_mult = !r_op.is_div;
                bus.md_ctrl_div  = r_op.is_div;
            end
            ST_RUN: bus.stall = 1'b1;
            ST_WB: begin
                bus.stall = bus.w_we;
                bus.done  = !bus.w_we;
                if (r_res.exc) begin
                    bus.wb_reg  = RSTATUS;
                    bus.wb_data = r_op.is_div ? EXC_DIV : EXC_MULT;
                end else begin
                    bus.wb_reg  = r_op.rd;
                    bus.wb_data = r_res.data;
                end
            end
            default: bus.stall = 1'b0;
        endcase
        bus.wb_valid    = bus.done && (r_res.exc || (r_op.rd != R0));
        bus.busy        = (r_state != ST_IDLE);
        bus.busy_rd     = bus.busy ? r_op.rd : R0;
        bus.timeout_err = r_timeout_err;
    end

endmodule

// File: tb/tb_multdiv_sequencer.sv
// Self-checking bench: vector table, reset corner cases and random ops
// scored against a cycle-count reference model.
module tb_multdiv_sequencer;

    typedef struct {
        logic        s;
        logic        is_div;
        logic [4:0]  rd;
        logic [31:0] res;
        logic        exc;
        int          r;
        int          h;
        logic        tail;
        int          e_done;
        logic        e_valid;
        logic [4:0]  e_reg;
        logic [31:0] e_data;
        logic        e_tmo;
    } vec_t;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;
    logic sticky [2];

    logic        sel = 1'b0;
    logic        t_issue_valid = 1'b0;
    logic        t_is_div = 1'b0;
    logic [4:0]  t_rd = '0;
    logic        t_ready = 1'b0;
    logic        t_exc = 1'b0;
    logic [31:0] t_result = '0;
    logic        t_wwe = 1'b0;

    multdiv_sequencer_if bus0();
    multdiv_sequencer_if bus1();

    assign bus0.issue_valid  = t_issue_valid && !sel;
    assign bus1.issue_valid  = t_issue_valid && sel;
    assign bus0.issue_is_div = t_is_div;
    assign bus1.issue_is_div = t_is_div;
    assign bus0.issue_rd     = t_rd;
    assign bus1.issue_rd     = t_rd;
    assign bus0.md_ready     = t_ready;
    assign bus1.md_ready     = t_ready;
    assign bus0.md_exception = t_exc;
    assign bus1.md_exception = t_exc;
    assign bus0.md_result    = t_result;
    assign bus1.md_result    = t_result;
    assign bus0.w_we         = t_wwe;
    assign bus1.w_we         = t_wwe;

    multdiv_sequencer #(
        .TIMEOUT (64), .EXC_MULT (4), .EXC_DIV (5)
    ) u_dut0 (
        .clock (clock), .reset (reset), .bus (bus0.master)
    );

    multdiv_sequencer #(
        .TIMEOUT (8), .EXC_MULT (4), .EXC_DIV (5)
    ) u_dut1 (
        .clock (clock), .reset (reset), .bus (bus1.master)
    );

    logic        o_mult, o_div, o_stall, o_done, o_wbv, o_busy, o_tmo;
    logic [4:0]  o_reg, o_brd;
    logic [31:0] o_data;

    assign o_mult  = sel ? bus1.md_ctrl_mult : bus0.md_ctrl_mult;
    assign o_div   = sel ? bus1.md_ctrl_div  : bus0.md_ctrl_div;
    assign o_stall = sel ? bus1.stall        : bus0.stall;
    assign o_done  = sel ? bus1.done         : bus0.done;
    assign o_wbv   = sel ? bus1.wb_valid     : bus0.wb_valid;
    assign o_busy  = sel ? bus1.busy         : bus0.busy;
    assign o_tmo   = sel ? bus1.timeout_err  : bus0.timeout_err;
    assign o_reg   = sel ? bus1.wb_reg       : bus0.wb_reg;
    assign o_brd   = sel ? bus1.busy_rd      : bus0.busy_rd;
    assign o_data  = sel ? bus1.wb_data      : bus0.wb_data;

    task automatic chk(input string nm, input int c,
                       input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", nm, c, act, exp);
        end
    endtask

    function automatic vec_t mk(
        input logic s, input logic is_div, input logic [4:0] rd,
        input logic [31:0] res, input logic exc, input int r,
        input int h, input logic tail, input int e_done,
        input logic e_valid, input logic [4:0] e_reg,
        input logic [31:0] e_data, input logic e_tmo);
        vec_t v;
        v.s = s; v.is_div = is_div; v.rd = rd; v.res = res;
        v.exc = exc; v.r = r; v.h = h; v.tail = tail;
        v.e_done = e_done; v.e_valid = e_valid; v.e_reg = e_reg;
        v.e_data = e_data; v.e_tmo = e_tmo;
        return v;
    endfunction

    // Reference: issue at cycle 0, START at 1, RUN from 2; WB the cycle
    // after md_ready or after TIMEOUT RUN cycles; each w_we cycle adds one.
    function automatic vec_t model(input vec_t v);
        int tmo;
        bit timed;
        bit fault;
        int wb;
        tmo   = v.s ? 8 : 64;
        timed = (v.r < 0) || (v.r >= tmo);
        wb    = timed ? 2 + tmo : 3 + v.r;
        fault = timed || v.exc;
        v.e_done  = wb + v.h;
        v.e_tmo   = timed;
        v.e_valid = fault || (v.rd != 5'd0);
        v.e_reg   = fault ? 5'd30 : v.rd;
        v.e_data  = fault ? (v.is_div ? 32'd5 : 32'd4) : v.res;
        return v;
    endfunction

    task automatic run_op(input vec_t v);
        int c_wb;
        int c_last;
        logic et;
        c_wb   = v.e_done - v.h;
        c_last = v.tail ? v.e_done + 1 : v.e_done;
        for (int c = 0; c <= c_last; c++) begin
            @(posedge clock);
            #1;
            if (c == 0) sel = v.s;
            t_issue_valid = (c == 0) ? 1'b1 :
                            (c <= v.e_done) ? 1'($urandom % 2) : 1'b0;
            t_is_div = (c == 0) ? v.is_div : 1'($urandom % 2);
            t_rd     = (c == 0) ? v.rd : 5'($urandom % 32);
            if (v.r >= 0 && c == 2 + v.r) begin
                t_ready  = 1'b1;
                t_exc    = v.exc;
                t_result = v.res;
            end else begin
                t_ready  = (c < 2 || c >= c_wb) ? 1'($urandom % 2) : 1'b0;
                t_exc    = 1'($urandom % 2);
                t_result = $urandom;
            end
            t_wwe = (c >= c_wb && c < v.e_done) ? 1'b1 :
                    (c < c_wb) ? 1'($urandom % 2) : 1'b0;
            @(negedge clock);
            et = sticky[v.s] || (v.e_tmo && c >= c_wb);
            chk("stall", c, 32'(o_stall), 32'(c < v.e_done));
            chk("done", c, 32'(o_done), 32'(c == v.e_done));
            chk("wb_valid", c, 32'(o_wbv), 32'((c == v.e_done) && v.e_valid));
            if (c == v.e_done && v.e_valid) begin
                chk("wb_reg", c, 32'(o_reg), 32'(v.e_reg));
                chk("wb_data", c, o_data, v.e_data);
            end
            chk("ctrl_mult", c, 32'(o_mult), 32'(c == 1 && !v.is_div));
            chk("ctrl_div", c, 32'(o_div), 32'(c == 1 && v.is_div));
            chk("busy", c, 32'(o_busy), 32'(c >= 1 && c <= v.e_done));
            chk("busy_rd", c, 32'(o_brd),
                (c >= 1 && c <= v.e_done) ? 32'(v.rd) : 32'd0);
            chk("timeout_err", c, 32'(o_tmo), 32'(et));
        end
        sticky[v.s] = sticky[v.s] || v.e_tmo;
    endtask

    task automatic chk_zero(input string nm);
        chk({nm, "_ctl0"}, -1, 32'({bus0.md_ctrl_mult, bus0.md_ctrl_div,
            bus0.stall, bus0.done, bus0.wb_valid, bus0.busy,
            bus0.timeout_err, bus0.wb_reg, bus0.busy_rd}), 32'd0);
        chk({nm, "_dat0"}, -1, bus0.wb_data, 32'd0);
        chk({nm, "_ctl1"}, -1, 32'({bus1.md_ctrl_mult, bus1.md_ctrl_div,
            bus1.stall, bus1.done, bus1.wb_valid, bus1.busy,
            bus1.timeout_err, bus1.wb_reg, bus1.busy_rd}), 32'd0);
        chk({nm, "_dat1"}, -1, bus1.wb_data, 32'd0);
    endtask

    vec_t tbl [11];
    vec_t v;

    initial begin
        tbl[0]  = mk(0, 0,  5, 32'h1234_5678, 0,  9, 0, 1,
                     12, 1,  5, 32'h1234_5678, 0);
        tbl[1]  = mk(0, 1,  7, 32'h0000_AAAA, 1,  2, 0, 1,
                     5,  1, 30, 32'd5, 0);
        tbl[2]  = mk(0, 0,  9, 32'h0000_CAFE, 0,  0, 3, 1,
                     6,  1,  9, 32'h0000_CAFE, 0);
        tbl[3]  = mk(0, 0,  0, 32'h0000_0055, 0,  1, 0, 1,
                     4,  0,  0, 32'd0, 0);
        tbl[4]  = mk(0, 0,  0, 32'h0000_0066, 1,  4, 1, 1,
                     8,  1, 30, 32'd4, 0);
        tbl[5]  = mk(0, 1, 31, 32'hFFFF_FFFF, 0,  0, 0, 0,
                     3,  1, 31, 32'hFFFF_FFFF, 0);
        tbl[6]  = mk(0, 1, 17, 32'h8000_0001, 0,  0, 0, 1,
                     3,  1, 17, 32'h8000_0001, 0);
        tbl[7]  = mk(1, 1,  3, 32'h0000_0000, 0, -1, 0, 1,
                     10, 1, 30, 32'd5, 1);
        tbl[8]  = mk(1, 0,  4, 32'h0000_0001, 0, -1, 2, 1,
                     12, 1, 30, 32'd4, 1);
        tbl[9]  = mk(1, 0,  6, 32'h0000_0077, 0,  7, 0, 1,
                     10, 1,  6, 32'h0000_0077, 0);
        tbl[10] = mk(0, 0, 12, 32'h0BAD_F00D, 0,  3, 0, 1,
                     6,  1, 12, 32'h0BAD_F00D, 0);
        sticky[0] = 1'b0;
        sticky[1] = 1'b0;

        #12;
        chk_zero("reset");
        #1 reset = 1'b1;

        for (int i = 0; i < 10; i++) run_op(tbl[i]);

        // Abort an op in RUN, then feed a stray md_ready while idle.
        @(posedge clock); #1;
        sel = 1'b0; t_issue_valid = 1'b1; t_is_div = 1'b0;
        t_rd = 5'd12; t_ready = 1'b0; t_wwe = 1'b0;
        @(posedge clock); #1 t_issue_valid = 1'b0;
        @(posedge clock); #1;
        @(posedge clock); #1;
        #2 reset = 1'b0;
        #1 chk_zero("mid_reset");
        sticky[0] = 1'b0;
        sticky[1] = 1'b0;
        @(posedge clock); #3 reset = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(posedge clock); #1;
            t_ready = (k == 0); t_exc = 1'b1; t_result = 32'hDEAD_0000;
            @(negedge clock);
            chk("stray_ready", k, 32'({bus0.busy, bus0.done, bus0.stall,
                bus0.wb_valid, bus0.md_ctrl_mult, bus0.md_ctrl_div}), 32'd0);
        end
        t_ready = 1'b0;
        run_op(tbl[10]);

        for (int i = 0; i < 30; i++) begin
            v.s      = (i >= 24);
            v.is_div = 1'($urandom % 2);
            v.rd     = 5'($urandom % 32);
            v.res    = $urandom;
            v.exc    = ($urandom % 4) == 0;
            v.r      = v.s ? int'($urandom_range(0, 10)) - 1
                           : int'($urandom_range(0, 20));
            v.h      = int'($urandom_range(0, 3));
            v.tail   = 1'($urandom % 2);
            v        = model(v);
            run_op(v);
        end

        @(posedge clock); #1;
        t_issue_valid = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
